// File: rtl/ibex_fetch_realign.sv
// Fetch realigner: buffers 32-bit fetch words and presents one 16/32-bit instruction with its PC.
// Optional macro IBEX_FETCH_REALIGN_BYPASS_EN forwards the incoming word when the buffer is empty.
module ibex_fetch_realign #(
    parameter int unsigned Depth    = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [31:0]     data_q [Depth];
    logic            err_q  [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_nx;
    logic [CntW-1:0] count_q, count_d;
    logic            off_q, off_d;
    logic [31:0]     pc_q, pc_d;

    logic            e0_vld, e1_vld;
    logic            e0_err, e1_err;
    logic [31:0]     e0_data;
    logic [15:0]     e1_lo;
    logic [15:0]     half;
    logic            bypass;
    logic            is_comp;
    logic            span_err;
    logic            fire;
    logic            pop_hs;
    logic            store_pop;
    logic            push_store;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_addr_i[0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_ptr_nx  = ptr_inc(rd_ptr_q);
    assign in_ready_o = (count_q < CntW'(Depth));

    // Oldest two entries; in bypass mode the incoming word stands in for e0.
    always_comb begin
        e0_vld  = (count_q != '0);
        e1_vld  = (count_q >= CntW'(2));
        e0_data = data_q[rd_ptr_q];
        e0_err  = err_q[rd_ptr_q];
        e1_lo   = data_q[rd_ptr_nx][15:0];
        e1_err  = err_q[rd_ptr_nx];
        bypass  = 1'b0;
`ifdef IBEX_FETCH_REALIGN_BYPASS_EN
        if (!e0_vld && !off_q && in_valid_i) begin
            bypass  = 1'b1;
            e0_vld  = 1'b1;
            e0_data = in_rdata_i;
            e0_err  = in_err_i;
        end
`endif
    end

    always_comb begin
        half            = off_q ? e0_data[31:16] : e0_data[15:0];
        is_comp         = (half[1:0] != 2'b11);
        out_valid_o     = e0_vld & (is_comp | ~off_q | e1_vld | e0_err);
        out_rdata_o     = off_q ? {(e1_vld ? e1_lo : 16'h0000), e0_data[31:16]} : e0_data;
        out_addr_o      = pc_q;
        span_err        = off_q & ~is_comp & e1_vld & e1_err;
        out_err_o       = out_valid_o & (e0_err | span_err);
        out_err_plus2_o = out_valid_o & ~e0_err & span_err;
    end

    // A forwarded uncompressed word consumed in the same cycle never enters the buffer.
    always_comb begin
        fire       = out_valid_o & out_ready_i;
        pop_hs     = fire & (~is_comp | off_q);
        store_pop  = pop_hs & ~bypass;
        push_store = in_valid_i & in_ready_o & ~clear_i & ~(bypass & pop_hs);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        off_d    = off_q;
        pc_d     = pc_q;

        if (push_store) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (store_pop) begin
            rd_ptr_d = rd_ptr_nx;
        end
        if (push_store && !store_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_store && store_pop) begin
            count_d = count_q - 1'b1;
        end
        if (fire) begin
            pc_d = pc_q + (is_comp ? 32'd2 : 32'd4);
            if (is_comp) begin
                off_d = ~off_q;
            end
        end

        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            off_d    = redirect_addr_i[1];
            pc_d     = {redirect_addr_i[31:1], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            off_q    <= 1'b0;
            pc_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            off_q    <= off_d;
            pc_q     <= pc_d;
        end
    end

    if (ResetAll) begin : g_store_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    data_q[i] <= '0;
                    err_q[i]  <= 1'b0;
                end
            end else if (push_store) begin
                data_q[wr_ptr_q] <= in_rdata_i;
                err_q[wr_ptr_q]  <= in_err_i;
            end
        end
    end else begin : g_store
        always_ff @(posedge clk_i) begin
            if (push_store) begin
                data_q[wr_ptr_q] <= in_rdata_i;
                err_q[wr_ptr_q]  <= in_err_i;
            end
        end
    end

endmodule
